// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_if_pkg
//  Description : Shared widths, FSM state and memory-op encodings for the
//                two-port cache-to-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  localparam int unsigned c_ADDR_W = 28;
  localparam int unsigned c_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin grant; a tie goes to the client
//                that did not win last time.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  assign o_valid = i_req0 | i_req1;
  assign o_grant = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_2p
//  Description : Serialises block reads/writes from an I-cache (port 0) and a
//                D-cache (port 1) onto one shared memory port, round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_2p
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_ready,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            r_state;
  op_t               r_op;
  logic              r_owner;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_c0_ready;
  logic              r_c1_ready;

  logic w_req0;
  logic w_req1;
  logic w_grant_valid;
  logic w_grant;
  logic w_sel_write;
  logic w_in_mem;

  assign w_req0 = c0_read | c0_write;
  assign w_req1 = c1_read | c1_write;

  rr_arbiter2 u_arb (
    .i_req0      (w_req0),
    .i_req1      (w_req1),
    .i_last_grant(r_last_grant),
    .o_valid     (w_grant_valid),
    .o_grant     (w_grant)
  );

  // Write wins if a client illegally raises both read and write.
  assign w_sel_write = w_grant ? c1_write : c0_write;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_RD;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_c0_ready   <= 1'b0;
      r_c1_ready   <= 1'b0;
    end else begin
      r_c0_ready <= 1'b0;
      r_c1_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant;
            r_op         <= w_sel_write ? OP_WR : OP_RD;
            r_addr       <= w_grant ? c1_addr : c0_addr;
            r_wdata      <= w_grant ? c1_wdata : c0_wdata;
            r_last_grant <= w_grant;
            r_state      <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (r_op == OP_RD) begin
              r_rdata <= mem_rdata;
            end
            r_c0_ready <= ~r_owner;
            r_c1_ready <= r_owner;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Owner's request drops off its ready, so nothing is sampled here.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Request drops combinationally on mem_ready, matching the cache handshake.
  assign w_in_mem  = (r_state == ST_MEM);
  assign mem_read  = w_in_mem & (r_op == OP_RD) & ~mem_ready;
  assign mem_write = w_in_mem & (r_op == OP_WR) & ~mem_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign c0_ready = r_c0_ready;
  assign c1_ready = r_c1_ready;
  assign c0_rdata = r_rdata;
  assign c1_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_2p
//  Description : Scoreboard bench for mem_arbiter_2p with a behavioural memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_2p;

  logic         clk;
  logic         proc_reset;
  logic         c0_read, c0_write, c1_read, c1_write;
  logic [27:0]  c0_addr, c1_addr;
  logic [127:0] c0_wdata, c1_wdata;
  logic [127:0] c0_rdata, c1_rdata;
  logic         c0_ready, c1_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  mem_arbiter_2p dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .c0_read   (c0_read),
    .c0_write  (c0_write),
    .c0_addr   (c0_addr),
    .c0_wdata  (c0_wdata),
    .c0_rdata  (c0_rdata),
    .c0_ready  (c0_ready),
    .c1_read   (c1_read),
    .c1_write  (c1_write),
    .c1_addr   (c1_addr),
    .c1_wdata  (c1_wdata),
    .c1_rdata  (c1_rdata),
    .c1_ready  (c1_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } mem_txn_t;

  typedef struct {
    bit           client;
    bit           chk;
    logic [127:0] rdata;
  } resp_t;

  mem_txn_t exp_mem[$];
  resp_t    exp_resp[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  int mem_ready_cyc  = -100;
  int last_ready_cyc = -100;
  int gap_base  = 0;
  int req_cyc   = 0;
  bit check_gap   = 1'b0;
  bit check_start = 1'b0;

  localparam logic [127:0] c_A5   = {8{16'hA5A5}};
  localparam logic [127:0] c_D0   = 128'hD0D0_0001_D0D0_0002_D0D0_0003_D0D0_0004;
  localparam logic [127:0] c_WD1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] c_JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_txn(input bit c, input bit wr, input logic [27:0] a,
                         input logic [127:0] wd, input logic [127:0] rd);
    mem_txn_t m;
    resp_t    r;
    m.wr = wr; m.addr = a; m.wdata = wd; m.rdata = rd;
    r.client = c; r.chk = !wr; r.rdata = rd;
    exp_mem.push_back(m);
    exp_resp.push_back(r);
  endtask

  // Holds the request until the matching ready, then drops it after the edge.
  task automatic client_txn(input bit c, input bit wr, input logic [27:0] a, input logic [127:0] d);
    bit done = 1'b0;
    if (c) begin c1_read = !wr; c1_write = wr; c1_addr = a; c1_wdata = d; end
    else   begin c0_read = !wr; c0_write = wr; c0_addr = a; c0_wdata = d; end
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = c ? c1_ready : c0_ready;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL client%0d_timeout: ready never seen, required within 200 cycles", c);
    end
    @(posedge clk); #1;
    if (c) begin c1_read = 1'b0; c1_write = 1'b0; end
    else   begin c0_read = 1'b0; c0_write = 1'b0; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 proc_reset = 1'b1;
    @(posedge clk); #1 proc_reset = 1'b0;
    gap_base = cyc;
  endtask

  // Memory model: checks each transaction against the scoreboard, answers after mem_lat.
  initial begin
    mem_txn_t e;
    bit ab;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!proc_reset && (mem_read || mem_write)) begin
        if (exp_mem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_mem_txn: read=%b write=%b addr=%h, none expected", mem_read, mem_write, mem_addr);
          continue;
        end
        e = exp_mem.pop_front();
        check("mem_op", {126'b0, mem_write, mem_read}, e.wr ? 128'd2 : 128'd1);
        check("mem_addr", 128'(mem_addr), 128'(e.addr));
        if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
        if (check_gap && last_ready_cyc >= gap_base)
          check("idle_gap", 128'(cyc), 128'(last_ready_cyc + 2));
        if (check_start) check("mem_start_latency", 128'(cyc), 128'(req_cyc + 1));
        ab = 1'b0;
        for (int k = 0; k < mem_lat; k++) begin
          @(negedge clk);
          if (proc_reset) begin ab = 1'b1; break; end
        end
        if (!ab) begin
          #1;
          check("mem_addr_hold", 128'(mem_addr), 128'(e.addr));
          if (e.wr) check("mem_wdata_hold", mem_wdata, e.wdata);
          mem_rdata = e.rdata;
          mem_ready = 1'b1;
          mem_ready_cyc = cyc;
          @(negedge clk); #1;
          mem_ready = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    resp_t r;
    if (c0_ready || c1_ready) begin
      if (exp_resp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ready: c0_ready=%b c1_ready=%b, required no ready", c0_ready, c1_ready);
      end else begin
        r = exp_resp.pop_front();
        check("ready_onehot", {127'b0, c0_ready & c1_ready}, 128'd0);
        check("ready_client", {127'b0, c1_ready}, {127'b0, r.client});
        if (r.chk) check("client_rdata", r.client ? c1_rdata : c0_rdata, r.rdata);
        check("ready_latency", 128'(cyc), 128'(mem_ready_cyc + 1));
        last_ready_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    proc_reset = 1'b1;
    c0_read = 0; c0_write = 0; c0_addr = '0; c0_wdata = '0;
    c1_read = 0; c1_write = 0; c1_addr = '0; c1_wdata = '0;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;

    @(negedge clk);
    check("rst_mem_read",  {127'b0, mem_read},  128'd0);
    check("rst_mem_write", {127'b0, mem_write}, 128'd0);
    check("rst_mem_addr",  128'(mem_addr), 128'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
    check("rst_c0_ready",  {127'b0, c0_ready}, 128'd0);
    check("rst_c1_ready",  {127'b0, c1_ready}, 128'd0);
    check("rst_c0_rdata",  c0_rdata, 128'd0);
    check("rst_c1_rdata",  c1_rdata, 128'd0);

    // Single read from client 0.
    @(posedge clk); #1;
    mem_lat = 2;
    req_cyc = cyc;
    check_start = 1'b1;
    exp_txn(1'b0, 1'b0, 28'h0000010, '0, c_A5);
    fork
      client_txn(1'b0, 1'b0, 28'h0000010, '0);
      begin
        @(negedge clk);
        check("idle_no_mem_read", {127'b0, mem_read}, 128'd0);
        @(negedge clk);
        check("t1_mem_read", {127'b0, mem_read}, 128'd1);
        check("t1_mem_addr", 128'(mem_addr), 128'h10);
      end
    join
    check_start = 1'b0;

    // Simultaneous c0 read and c1 write.
    do_reset();
    mem_lat = 1;
    exp_txn(1'b0, 1'b0, 28'h0000100, '0, c_D0);
    exp_txn(1'b1, 1'b1, 28'h0000200, c_WD1, c_JUNK);
    fork
      client_txn(1'b0, 1'b0, 28'h0000100, '0);
      client_txn(1'b1, 1'b1, 28'h0000200, c_WD1);
    join
    check("rdata_after_write", c1_rdata, c_D0);

    // Continuous requests from both clients alternate.
    do_reset();
    mem_lat = 1;
    check_gap = 1'b1;
    exp_txn(1'b0, 1'b0, 28'h0000A00, '0, 128'h0A00);
    exp_txn(1'b1, 1'b1, 28'h0000B01, 128'hB01B01, c_JUNK);
    exp_txn(1'b0, 1'b0, 28'h0000A02, '0, 128'h0A02_0A02);
    exp_txn(1'b1, 1'b0, 28'h0000B03, '0, 128'h0B03_0B03_0B03);
    fork
      begin
        client_txn(1'b0, 1'b0, 28'h0000A00, '0);
        client_txn(1'b0, 1'b0, 28'h0000A02, '0);
      end
      begin
        client_txn(1'b1, 1'b1, 28'h0000B01, 128'hB01B01);
        client_txn(1'b1, 1'b0, 28'h0000B03, '0);
      end
    join

    // Owner changes address and non-owner requests while in MEM.
    do_reset();
    mem_lat = 4;
    exp_txn(1'b0, 1'b0, 28'h0ABCDE0, '0, 128'hC0C0_C0C0);
    exp_txn(1'b1, 1'b0, 28'h0123456, '0, 128'hC1C1_C1C1_C1C1);
    fork
      client_txn(1'b0, 1'b0, 28'h0ABCDE0, '0);
      begin
        repeat (2) @(posedge clk);
        #1 c0_addr = 28'hFFFFFFF;
        client_txn(1'b1, 1'b0, 28'h0123456, '0);
      end
    join
    check_gap = 1'b0;

    // Asynchronous reset in the middle of a memory read.
    do_reset();
    mem_lat = 20;
    exp_mem.push_back('{wr: 1'b0, addr: 28'h0000777, wdata: '0, rdata: c_JUNK});
    c0_read = 1'b1; c0_addr = 28'h0000777;
    repeat (3) @(negedge clk);
    check("pre_reset_mem_read", {127'b0, mem_read}, 128'd1);
    #1 proc_reset = 1'b1;
    #1;
    check("async_rst_mem_read",  {127'b0, mem_read},  128'd0);
    check("async_rst_mem_write", {127'b0, mem_write}, 128'd0);
    check("async_rst_c0_ready",  {127'b0, c0_ready},  128'd0);
    check("async_rst_c1_ready",  {127'b0, c1_ready},  128'd0);
    check("async_rst_rdata",     c0_rdata, 128'd0);
    c0_read = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 proc_reset = 1'b0;
    mem_lat = 1;
    exp_txn(1'b0, 1'b0, 28'h0000888, '0, 128'h8888);
    client_txn(1'b0, 1'b0, 28'h0000888, '0);

    // Stray mem_ready in IDLE, then a minimum-latency transaction.
    do_reset();
    @(negedge clk); #1 mem_ready = 1'b1;
    @(negedge clk); #1 mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_stray_c0_ready", {127'b0, c0_ready}, 128'd0);
      check("idle_stray_c1_ready", {127'b0, c1_ready}, 128'd0);
      check("idle_stray_mem_read", {127'b0, mem_read}, 128'd0);
    end
    @(posedge clk); #1;
    mem_lat = 0;
    exp_txn(1'b1, 1'b0, 28'h0000999, '0, 128'h9999_0000_9999);
    client_txn(1'b1, 1'b0, 28'h0000999, '0);

    repeat (3) @(negedge clk);
    check("mem_queue_drained",  128'(exp_mem.size()),  128'd0);
    check("resp_queue_drained", 128'(exp_resp.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
